// File: rtl/mbscore_bus_arbiter_pkg.sv
// Shared types and constants for the MBScore bus arbiter.
// The optional round-robin arbitration is selected with MBSCORE_BUS_RR_EN.
package mbscore_bus_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_ADDR_WIDTH  = 32;
    localparam int DEFAULT_NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } bus_state_e;

    function automatic logic state_busy(input bus_state_e s);
        return s != ST_IDLE;
    endfunction

    function automatic int rr_pos(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/mbscore_bus_arbiter_if.sv
// Master-side request/response bus plus the single-port RAM bus of the arbiter.
interface mbscore_bus_arbiter_if
    import mbscore_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS
);

    logic [NUM_MASTERS-1:0]            m_req;
    logic [NUM_MASTERS-1:0]            m_we;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]            m_gnt;
    logic [NUM_MASTERS-1:0]            m_rvalid;
    logic [DATA_WIDTH-1:0]             m_rdata;
    logic [ADDR_WIDTH-1:0]             ram_addr;
    logic                              ram_re;
    logic                              ram_we;
    logic [DATA_WIDTH-1:0]             ram_wdata;
    logic [DATA_WIDTH-1:0]             ram_rdata;
    logic                              busy;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, ram_rdata,
        output m_gnt, m_rvalid, m_rdata, ram_addr, ram_re, ram_we, ram_wdata, busy
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, ram_rdata,
        input  m_gnt, m_rvalid, m_rdata, ram_addr, ram_re, ram_we, ram_wdata, busy
    );

endinterface

// File: rtl/mbscore_bus_arbiter_prio.sv
// Request arbiter: fixed priority (highest index wins) by default,
// round-robin with a registered last-winner pointer when MBSCORE_BUS_RR_EN is defined.
module mbscore_bus_arbiter_prio
    import mbscore_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
`ifdef MBSCORE_BUS_RR_EN
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   advance_i,
`endif
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   any_o
);

    localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] idx_s;

`ifdef MBSCORE_BUS_RR_EN
    logic [IDX_W-1:0] ptr_q;

    // Search downward so the index right after the last winner is assigned last and wins.
    always_comb begin
        idx_s = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx_s = req_i[IDX_W'(rr_pos(int'(ptr_q), k, NUM_MASTERS))]
                  ? IDX_W'(rr_pos(int'(ptr_q), k, NUM_MASTERS)) : idx_s;
        end
    end

    // Last-winner pointer; reset value makes master 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IDX_W'(NUM_MASTERS - 1);
        end else if (advance_i && any_o) begin
            ptr_q <= idx_s;
        end else begin
            ptr_q <= ptr_q;
        end
    end
`else
    // Fixed priority: later (higher) indices overwrite earlier ones.
    always_comb begin
        idx_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx_s = req_i[i] ? IDX_W'(i) : idx_s;
        end
    end
`endif

    assign any_o = |req_i;
    assign idx_o = idx_s;
    assign gnt_o = any_o ? (ONE << idx_s) : '0;

endmodule

// File: rtl/mbscore_bus_arbiter.sv
// Multi-master to single-port RAM arbiter: IDLE -> ACCESS -> [WAIT] -> RESP.
// Arbitration mode is selected in the prio sub-module by MBSCORE_BUS_RR_EN.
module mbscore_bus_arbiter
    import mbscore_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int RAM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mbscore_bus_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [1:0] LAST_WAIT = 2'(RAM_LATENCY - 2);
    localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    bus_state_e state_q, state_d;
    // ACCESS spans two cycles: the grant cycle (0) and the RAM strobe cycle (1).
    logic                   issue_q, issue_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]  ram_wdata_q, ram_wdata_d;
    logic                   ram_re_q, ram_re_d;
    logic                   ram_we_q, ram_we_d;
    logic                   busy_q, busy_d;

    logic [NUM_MASTERS-1:0] win_gnt_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic                   win_any_s;
    logic                   take_s;
    logic                   strobe_s;

    mbscore_bus_arbiter_prio #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_prio (
`ifdef MBSCORE_BUS_RR_EN
        .clk       (clk),
        .rst       (rst),
        .advance_i (state_q == ST_IDLE),
`endif
        .req_i     (bus.m_req),
        .gnt_o     (win_gnt_s),
        .idx_o     (win_idx_s),
        .any_o     (win_any_s)
    );

    assign take_s   = (state_q == ST_IDLE) && win_any_s;
    assign strobe_s = (state_q == ST_ACCESS) && !issue_q;

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            issue_q     <= 1'b0;
            cnt_q       <= 2'd0;
            owner_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_re_q    <= ram_re_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and request-latch logic.
    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any_s) begin
                    state_d = ST_ACCESS;
                    issue_d = 1'b0;
                    owner_d = win_idx_s;
                    we_d    = bus.m_we[win_idx_s];
                    addr_d  = bus.m_addr[int'(win_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = bus.m_wdata[int'(win_idx_s) * DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!issue_q) begin
                    issue_d = 1'b1;
                end else if (we_q) begin
                    state_d = ST_IDLE;
                end else if (RAM_LATENCY == 1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 2'd0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values, registered in the same flop bank as the state.
    always_comb begin
        gnt_d       = take_s ? win_gnt_s : '0;
        ram_re_d    = strobe_s && !we_q;
        ram_we_d    = strobe_s && we_q;
        ram_addr_d  = strobe_s ? addr_q : ram_addr_q;
        ram_wdata_d = strobe_s ? wdata_q : ram_wdata_q;
        rvalid_d    = (state_q == ST_RESP) ? (ONE << owner_q) : '0;
        rdata_d     = (state_q == ST_RESP) ? bus.ram_rdata : rdata_q;
        busy_d      = state_busy(state_d);
    end

    assign bus.m_gnt     = gnt_q;
    assign bus.m_rvalid  = rvalid_q;
    assign bus.m_rdata   = rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.busy      = busy_q;

endmodule
